// File: rtl/mulcol_acc8_p32.sv
// Purpose: accumulates a frame of GF(2^13) elements through an external 8-product constant-multiplier column, then drains the 8 lane sums.
// Latency: the drain starts on the cycle after the last beat is accepted, with one lane per out handshake and 8 handshakes per frame.
// Backpressure: in_ready drops for the whole drain, and out_* hold stable while out_ready is low.
module mulcol_acc8_p32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [12:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [12:0] mc_b,
    input  logic [12:0] mc_p1,
    input  logic [12:0] mc_p2,
    input  logic [12:0] mc_p3,
    input  logic [12:0] mc_p4,
    input  logic [12:0] mc_p5,
    input  logic [12:0] mc_p6,
    input  logic [12:0] mc_p7,
    input  logic [12:0] mc_p8,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_data,
    output logic [2:0]  out_idx,
    output logic        out_last,
    output logic [5:0]  frame_len
);

    typedef enum logic {ACC, DRAIN} state_t;

    state_t      state;
    logic        first_beat;
    logic [2:0]  idx;
    logic [12:0] acc  [0:7];
    logic [12:0] prod [0:7];
    logic        accept;

    assign prod[0] = mc_p1;
    assign prod[1] = mc_p2;
    assign prod[2] = mc_p3;
    assign prod[3] = mc_p4;
    assign prod[4] = mc_p5;
    assign prod[5] = mc_p6;
    assign prod[6] = mc_p7;
    assign prod[7] = mc_p8;

    assign in_ready = (state == ACC);
    assign accept   = in_valid && in_ready;

    // The column is fed zero while draining so it never sees stale or stalled input.
    assign mc_b = (state == ACC) ? in_data : 13'd0;

    // Outputs depend only on registered state, never on in_* or mc_p*.
    assign out_valid = (state == DRAIN);
    assign out_data  = (state == DRAIN) ? acc[idx] : 13'd0;
    assign out_idx   = (state == DRAIN) ? idx : 3'd0;
    assign out_last  = (state == DRAIN) && (idx == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACC;
            first_beat <= 1'b1;
            idx        <= 3'd0;
            frame_len  <= 6'd0;
            for (int k = 0; k < 8; k++) begin
                acc[k] <= 13'd0;
            end
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        // The first beat overwrites, so no separate clear cycle is needed between frames.
                        for (int k = 0; k < 8; k++) begin
                            acc[k] <= first_beat ? prod[k] : (acc[k] ^ prod[k]);
                        end
                        first_beat <= 1'b0;
                        if (first_beat) begin
                            frame_len <= 6'd1;
                        end else if (frame_len != 6'd63) begin
                            frame_len <= frame_len + 6'd1;
                        end
                        if (in_last) begin
                            state <= DRAIN;
                            idx   <= 3'd0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx == 3'd7) begin
                            state      <= ACC;
                            first_beat <= 1'b1;
                            idx        <= 3'd0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule
